// File: rtl/comm_master.sv
// Host-side link master: sends a 3-byte command frame over 8N1 UART TX and
// captures single-byte responses from RX with a host-cleared ready flag.
module comm_master #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        snd_cmd,
    output logic        frm_snt,
    output logic        resp_rdy,
    output logic [7:0]  resp,
    input  logic        clr_resp_rdy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_MID  = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BYTE_HI  = 2'd1,
        ST_BYTE_MID = 2'd2,
        ST_BYTE_LO  = 2'd3
    } frm_state_t;

    frm_state_t      frm_state_r, frm_next_s;
    logic [15:0]     data_r;
    logic            frm_snt_r;
    logic            accept_s, load_s, frame_end_s, tx_done_s;
    logic [7:0]      load_byte_s;

    logic            tx_r, tx_busy_r;
    logic [8:0]      tx_shift_r;
    logic [CW-1:0]   tx_baud_cnt_r;
    logic [3:0]      tx_bit_cnt_r;

    logic            rx_meta_r, rx_sync_r, rx_prev_r;
    logic            rx_busy_r, rx_start_s, rx_tick_s, rx_done_s;
    logic [CW-1:0]   rx_baud_cnt_r;
    logic [3:0]      rx_bit_cnt_r;
    logic [7:0]      rx_shift_r, resp_r;
    logic            resp_rdy_r;

    assign TX       = tx_r;
    assign frm_snt  = frm_snt_r;
    assign resp_rdy = resp_rdy_r;
    assign resp     = resp_r;

    assign tx_done_s = tx_busy_r && (tx_baud_cnt_r == BAUD_LAST) && (tx_bit_cnt_r == 4'd9);

    // Frame sequencing: next state and byte-load requests for the transmitter
    always_comb begin
        frm_next_s  = frm_state_r;
        accept_s    = 1'b0;
        load_s      = 1'b0;
        load_byte_s = 8'h00;
        frame_end_s = 1'b0;
        case (frm_state_r)
            ST_IDLE: begin
                if (snd_cmd) begin
                    accept_s    = 1'b1;
                    load_s      = 1'b1;
                    load_byte_s = cmd;
                    frm_next_s  = ST_BYTE_HI;
                end else begin
                    frm_next_s  = ST_IDLE;
                end
            end
            ST_BYTE_HI: begin
                if (tx_done_s) begin
                    load_s      = 1'b1;
                    load_byte_s = data_r[15:8];
                    frm_next_s  = ST_BYTE_MID;
                end else begin
                    frm_next_s  = ST_BYTE_HI;
                end
            end
            ST_BYTE_MID: begin
                if (tx_done_s) begin
                    load_s      = 1'b1;
                    load_byte_s = data_r[7:0];
                    frm_next_s  = ST_BYTE_LO;
                end else begin
                    frm_next_s  = ST_BYTE_MID;
                end
            end
            ST_BYTE_LO: begin
                if (tx_done_s) begin
                    frame_end_s = 1'b1;
                    frm_next_s  = ST_IDLE;
                end else begin
                    frm_next_s  = ST_BYTE_LO;
                end
            end
            default: begin
                frm_next_s = ST_IDLE;
            end
        endcase
    end

    // Frame state, latched data word and the sticky frame-sent flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_state_r <= ST_IDLE;
            data_r      <= 16'h0000;
            frm_snt_r   <= 1'b0;
        end else begin
            frm_state_r <= frm_next_s;
            if (accept_s) begin
                data_r    <= data;
                frm_snt_r <= 1'b0;
            end else if (frame_end_s) begin
                frm_snt_r <= 1'b1;
            end
        end
    end

    // UART transmitter; a load starts the next start bit on the same edge so bytes run back-to-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r          <= 1'b1;
            tx_busy_r     <= 1'b0;
            tx_shift_r    <= 9'h1FF;
            tx_baud_cnt_r <= CNT_ZERO;
            tx_bit_cnt_r  <= 4'd0;
        end else if (load_s) begin
            tx_r          <= 1'b0;
            tx_busy_r     <= 1'b1;
            tx_shift_r    <= {1'b1, load_byte_s};
            tx_baud_cnt_r <= CNT_ZERO;
            tx_bit_cnt_r  <= 4'd0;
        end else if (tx_busy_r) begin
            if (tx_baud_cnt_r == BAUD_LAST) begin
                tx_baud_cnt_r <= CNT_ZERO;
                if (tx_bit_cnt_r == 4'd9) begin
                    tx_busy_r <= 1'b0;
                    tx_r      <= 1'b1;
                end else begin
                    tx_r         <= tx_shift_r[0];
                    tx_shift_r   <= {1'b1, tx_shift_r[8:1]};
                    tx_bit_cnt_r <= tx_bit_cnt_r + 4'd1;
                end
            end else begin
                tx_baud_cnt_r <= tx_baud_cnt_r + CNT_ONE;
            end
        end else begin
            tx_r <= 1'b1;
        end
    end

    assign rx_start_s = !rx_busy_r && rx_prev_r && !rx_sync_r;
    assign rx_tick_s  = rx_busy_r && (rx_baud_cnt_r == BAUD_LAST);
    assign rx_done_s  = rx_tick_s && (rx_bit_cnt_r == 4'd9);

    // RX synchronizer plus one history flop for falling-edge start detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // UART receiver: counter preloaded to mid-bit so every tick lands in a bit centre
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy_r     <= 1'b0;
            rx_baud_cnt_r <= CNT_ZERO;
            rx_bit_cnt_r  <= 4'd0;
            rx_shift_r    <= 8'h00;
        end else if (rx_start_s) begin
            rx_busy_r     <= 1'b1;
            rx_baud_cnt_r <= BAUD_MID;
            rx_bit_cnt_r  <= 4'd0;
        end else if (rx_tick_s) begin
            rx_baud_cnt_r <= CNT_ZERO;
            if (rx_bit_cnt_r == 4'd9) begin
                rx_busy_r <= 1'b0;
            end else begin
                if (rx_bit_cnt_r != 4'd0) begin
                    rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                end
                rx_bit_cnt_r <= rx_bit_cnt_r + 4'd1;
            end
        end else if (rx_busy_r) begin
            rx_baud_cnt_r <= rx_baud_cnt_r + CNT_ONE;
        end
    end

    // Response holding register; a completing byte wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_r     <= 8'h00;
            resp_rdy_r <= 1'b0;
        end else if (rx_done_s) begin
            resp_r     <= rx_shift_r;
            resp_rdy_r <= 1'b1;
        end else if (clr_resp_rdy) begin
            resp_rdy_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_comm_master.sv
// Self-checking bench for comm_master: table-driven frames with concurrent RX
// traffic, checked by a serial-line decoder and a response model.
module tb_comm_master;

    localparam int B = 16;

    logic        clk, rst_n, RX, TX, snd_cmd, frm_snt, resp_rdy, clr_resp_rdy;
    logic [7:0]  cmd, resp;
    logic [15:0] data;

    int          checks = 0;
    int          errors = 0;
    int          rst_cnt = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  model_resp = 8'h00;
    logic        model_rdy = 1'b0;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] data;
        logic        mid;
        logic        rx_en;
        logic [7:0]  rx;
        int          rx_delay;
        logic [7:0]  exp_b0, exp_b1, exp_b2, exp_resp;
    } tv_t;

    tv_t tv[9];

    comm_master #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
        .cmd(cmd), .data(data), .snd_cmd(snd_cmd),
        .frm_snt(frm_snt), .resp_rdy(resp_rdy), .resp(resp),
        .clr_resp_rdy(clr_resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge rst_n) rst_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: actual=%0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic tv_t mk(input logic [7:0] c, input logic [15:0] d, input logic mid,
                               input logic rx_en, input logic [7:0] rx, input int dly,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] er);
        tv_t t;
        t.cmd = c; t.data = d; t.mid = mid; t.rx_en = rx_en; t.rx = rx; t.rx_delay = dly;
        t.exp_b0 = e0; t.exp_b1 = e1; t.exp_b2 = e2; t.exp_resp = er;
        return t;
    endfunction

    // Serial-line decoder for TX: mid-bit sampling, bytes dropped if a reset hit them
    initial begin
        logic [7:0] b;
        logic       st, sp;
        int         rc;
        forever begin
            @(negedge TX);
            rc = rst_cnt;
            repeat (B / 2) @(posedge clk);
            #1 st = TX;
            for (int i = 0; i < 8; i++) begin
                repeat (B) @(posedge clk);
                #1 b[i] = TX;
            end
            repeat (B) @(posedge clk);
            #1 sp = TX;
            if (rc == rst_cnt) begin
                check("tx_framing", {30'd0, st, sp}, 32'h1);
                got_q.push_back(b);
            end
        end
    end

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk) RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [15:0] d, input logic mid);
        int cyc;
        bit done;
        @(negedge clk);
        cmd = c; data = d; snd_cmd = 1'b1;
        @(posedge clk);
        #1 snd_cmd = 1'b0;
        cmd = ~c; data = ~d;
        check("frm_snt_cleared", {31'd0, frm_snt}, 32'h0);
        repeat (2) @(posedge clk);
        #1 check("start_latency", {31'd0, TX}, 32'h0);
        cyc = 2;
        done = 1'b0;
        while (!done && cyc < 30 * B + 10) begin
            @(posedge clk);
            #1 cyc++;
            if (mid) begin
                snd_cmd = (cyc == 10 * B + 5);
                cmd = 8'hFF; data = 16'hFFFF;
            end
            if (frm_snt) done = 1'b1;
        end
        snd_cmd = 1'b0;
        check_rng("frame_time", cyc, 30 * B, 30 * B + 3);
    endtask

    task automatic pulse_clear();
        @(negedge clk) clr_resp_rdy = 1'b1;
        @(negedge clk) clr_resp_rdy = 1'b0;
        #1 check("resp_rdy_cleared", {31'd0, resp_rdy}, 32'h0);
        check("resp_kept", {24'd0, resp}, {24'd0, model_resp});
        model_rdy = 1'b0;
    endtask

    task automatic run_vector(input tv_t v);
        int w;
        got_q.delete();
        fork
            send_frame(v.cmd, v.data, v.mid);
            begin
                if (v.rx_en) begin
                    repeat (v.rx_delay) @(negedge clk);
                    send_rx(v.rx);
                end
            end
        join
        w = 0;
        while (got_q.size() < 3 && w < 4 * B) begin
            @(posedge clk);
            w++;
        end
        check("tx_byte_count", got_q.size(), 32'd3);
        if (got_q.size() >= 3) begin
            check("tx_byte0", {24'd0, got_q[0]}, {24'd0, v.exp_b0});
            check("tx_byte1", {24'd0, got_q[1]}, {24'd0, v.exp_b1});
            check("tx_byte2", {24'd0, got_q[2]}, {24'd0, v.exp_b2});
        end
        repeat (2 * B) @(posedge clk);
        #1 check("frm_snt_hold", {31'd0, frm_snt}, 32'h1);
        if (v.rx_en) begin
            model_resp = v.exp_resp;
            model_rdy  = 1'b1;
        end
        check("resp", {24'd0, resp}, {24'd0, model_resp});
        check("resp_rdy", {31'd0, resp_rdy}, {31'd0, model_rdy});
        if (model_rdy) pulse_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0]  rc;
        logic [15:0] rd;
        logic [7:0]  rb;
        bit          seen;

        rst_n = 1'b0; RX = 1'b1; cmd = 8'h00; data = 16'h0000;
        snd_cmd = 1'b0; clr_resp_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_TX", {31'd0, TX}, 32'h1);
        check("reset_frm_snt", {31'd0, frm_snt}, 32'h0);
        check("reset_resp_rdy", {31'd0, resp_rdy}, 32'h0);
        check("reset_resp", {24'd0, resp}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);

        tv[0] = mk(8'h01, 16'h0000, 1'b0, 1'b0, 8'h00, 0,     8'h01, 8'h00, 8'h00, 8'h00);
        tv[1] = mk(8'h04, 16'h800A, 1'b1, 1'b0, 8'h00, 0,     8'h04, 8'h80, 8'h0A, 8'h00);
        tv[2] = mk(8'h05, 16'h00FD, 1'b0, 1'b1, 8'hC0, 5 * B, 8'h05, 8'h00, 8'hFD, 8'hC0);
        for (int i = 3; i < 9; i++) begin
            rc = 8'($urandom);
            rd = 16'($urandom);
            rb = 8'($urandom);
            tv[i] = mk(rc, rd, 1'($urandom), 1'($urandom), rb, int'($urandom_range(0, 15 * B)),
                       rc, rd[15:8], rd[7:0], rb);
        end
        for (int i = 0; i < 9; i++) run_vector(tv[i]);

        send_rx(8'hA5);
        model_resp = 8'hA5; model_rdy = 1'b1;
        #1 check("rx_A5_rdy", {31'd0, resp_rdy}, 32'h1);
        check("rx_A5_resp", {24'd0, resp}, 32'hA5);
        pulse_clear();

        seen = 1'b0;
        fork
            send_rx(8'h3C);
            begin
                clr_resp_rdy = 1'b1;
                for (int c = 0; c < 12 * B && !seen; c++) begin
                    @(posedge clk);
                    #1 if (resp_rdy) begin
                        seen = 1'b1;
                        clr_resp_rdy = 1'b0;
                    end
                end
                clr_resp_rdy = 1'b0;
            end
        join
        model_resp = 8'h3C; model_rdy = 1'b1;
        check("set_wins_seen", {31'd0, seen}, 32'h1);
        check("set_wins_rdy", {31'd0, resp_rdy}, 32'h1);
        check("set_wins_resp", {24'd0, resp}, 32'h3C);

        send_rx(8'h5A);
        #1 check("pre_reset_rdy", {31'd0, resp_rdy}, 32'h1);
        @(negedge clk) cmd = 8'h33; data = 16'h1234; snd_cmd = 1'b1;
        @(negedge clk) snd_cmd = 1'b0;
        repeat (15 * B) @(negedge clk);
        rst_n = 1'b0;
        #1 check("midreset_TX", {31'd0, TX}, 32'h1);
        check("midreset_frm_snt", {31'd0, frm_snt}, 32'h0);
        check("midreset_resp_rdy", {31'd0, resp_rdy}, 32'h0);
        check("midreset_resp", {24'd0, resp}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_resp = 8'h00; model_rdy = 1'b0;
        repeat (12 * B) @(negedge clk);
        run_vector(mk(8'hA7, 16'h5E21, 1'b0, 1'b0, 8'h00, 0, 8'hA7, 8'h5E, 8'h21, 8'h00));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/comm_master.md
Name: comm_master

Overview:
- Host-side wireless-link master for bench and system use.
- Serializes a 3-byte command frame (opcode, data high byte, data low byte) over a UART TX line to the copter.
- Receives single-byte responses on RX and presents them with a ready flag the host clears.
- Contains one UART transmitter, one UART receiver and a frame-sequencing state machine.

Parameters:
BAUD_DIV, 2604, clocks per bit (50 MHz clk, 19200 baud); must be >= 16.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
RX  input  1  serial response line from copter, idle high, asynchronous to clk
TX  output  1  serial command line to copter, idle high
cmd  input  8  command opcode to send
data  input  16  data word sent with the opcode
snd_cmd  input  1  single-cycle request to send {cmd,data}
frm_snt  output  1  high once the full 3-byte frame has left TX
resp_rdy  output  1  high while an unread response byte is held in resp
resp  output  8  last received response byte
clr_resp_rdy  input  1  clears resp_rdy

Behaviour:
- Reset: TX=1, frm_snt=0, resp_rdy=0, resp=8'h00, all FSMs idle, counters 0.
- UART format: 8N1, LSB first, start bit 0, stop bit 1, each bit exactly BAUD_DIV clocks.
- Frame FSM states:
  - IDLE: on snd_cmd, latch cmd and data into internal registers, clear frm_snt, go to BYTE_HI. cmd and data may change afterwards without effect.
  - BYTE_HI: transmit latched cmd; on completion of stop bit go to BYTE_MID.
  - BYTE_MID: transmit data[15:8]; then BYTE_LO.
  - BYTE_LO: transmit data[7:0]; on its stop-bit completion set frm_snt, return to IDLE.
- Start bit of the opcode appears on TX no later than 2 clocks after snd_cmd is sampled.
- Bytes are sent back-to-back with at most 1 idle clock between a stop bit and the next start bit.
- Total frame time is 30*BAUD_DIV clocks (+3 max).
- frm_snt is a set/clear flag: set at frame end, held high until the next accepted snd_cmd or reset.
- snd_cmd while not IDLE is ignored; the frame in flight is unaffected.
- Receiver:
  - RX passes through a 2-flop synchronizer.
  - A start is detected on a synchronized high-to-low transition while the receiver is idle.
  - Each bit is sampled at mid-bit: start at BAUD_DIV/2, then every BAUD_DIV clocks.
  - 8 data bits are shifted LSB first.
  - At the stop-bit sample point: resp is loaded and resp_rdy is set, whatever value the stop bit has (no framing-error reporting).
- resp holds its value until the next complete byte is received.
- resp_rdy clears on clr_resp_rdy; if a set and a clear occur in the same cycle, set wins.
- Receiver and transmitter are independent and run concurrently; a response arriving mid-frame is captured normally.
- An asynchronous reset asserted mid-frame or mid-byte aborts immediately and restores all reset values; no partial byte is reported.

Test Plan:
- Reset, then snd_cmd with cmd=8'h01, data=16'h0000 -> TX carries bytes 01, 00, 00 (8N1, LSB first, 2604 clk/bit); frm_snt rises within 3 clocks after 30*2604 clocks and stays high until the next snd_cmd.
- snd_cmd with cmd=8'h04, data=16'h800A, then change cmd/data the next cycle -> TX bytes 04, 80, 0A; a second snd_cmd pulsed mid-frame is ignored.
- Model drives RX with byte 8'hA5 -> resp=8'hA5, resp_rdy=1 after about 9.5 bit times; clr_resp_rdy pulse -> resp_rdy=0 while resp stays 8'hA5.
- RX byte 8'hC0 arrives while a frame (cmd 8'h05, data 16'h00FD) is transmitting -> both complete correctly: resp=8'hC0, TX bytes 05, 00, FD.
- Assert clr_resp_rdy in the same cycle a new byte (8'h3C) completes -> resp_rdy=1, resp=8'h3C.
- Assert rst_n low midway through the second byte -> TX=1, frm_snt=0, resp_rdy=0 immediately; a subsequent snd_cmd sends a clean full frame.
